mont_mul_cios: RTL and testbench

- Parametrised word-serial Montgomery multiplier (CIOS: coarsely integrated operand scanning). Computes r = a*b*R^-1 mod m, where R = 2^(WORD_W*NUM_WORDS).
- Successor to the fixed 4x32-bit prime-field multiplier. Word width and word count are generics.
- Modulus m and its Montgomery constant are run-time ports, so one instance serves both the field prime and the curve order.
- Sits beside the Fp adder/subtractor and inverter in the EC datapath. Uses a start/busy/done handshake.

---
 rtl/mont_mul_cios_if.sv | 28 ++
 rtl/mont_mul_cios.sv | 163 ++++++++++++++++
 tb/tb_mont_mul_cios.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mont_mul_cios_if.sv
// Operand/result bundle for the word-serial Montgomery multiplier.
// start is sampled only when the engine is idle; busy covers the computation, done pulses once when r is valid.
interface mont_mul_cios_if #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4
);
  localparam int OP_W = WORD_W * NUM_WORDS;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic [OP_W-1:0]   m;
  logic [WORD_W-1:0] m_inv;
  logic              busy;
  logic              done;
  logic [OP_W-1:0]   r;
  logic [2:0]        dbg_state;

  modport master (
    output start, a, b, m, m_inv,
    input  busy, done, r, dbg_state
  );

  modport slave (
    input  start, a, b, m, m_inv,
    output busy, done, r, dbg_state
  );
endinterface

// File: rtl/mont_mul_cios.sv
// CIOS Montgomery multiplier: r = a*b*2^-(WORD_W*NUM_WORDS) mod m, one WORD_W x WORD_W multiply per cycle.
// The single multiplier is shared between the a*b pass, the q computation and the q*m reduction pass.
module mont_mul_cios #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4
) (
  input logic            clk,
  input logic            reset,
  mont_mul_cios_if.slave bus
);
  localparam int W    = WORD_W;
  localparam int N    = NUM_WORDS;
  localparam int OP_W = W * N;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int TW   = $clog2(N + 2);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_ACC, S_MQ, S_RED, S_FIN, S_SUB, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0][W-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
  logic [W-1:0]          minv_q, minv_d, c_q, c_d, q_q, q_d;
  logic [N+1:0][W-1:0]   t_q, t_d;
  logic [CW-1:0]         i_q, i_d, j_q, j_d, j_next;
  logic [OP_W-1:0]       r_q, r_d;

  logic [TW-1:0]         jt, jt_prev;
  logic [W-1:0]          mul_x, mul_y;
  logic [2*W-1:0]        prod, sum;
  logic [W:0]            top_sum;
  logic [OP_W+W-1:0]     t_low;
  logic                  sub_borrow;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_MUL;
      S_MUL:  if (j_q == LAST) state_d = S_ACC;
      S_ACC:  state_d = S_MQ;
      S_MQ:   state_d = S_RED;
      S_RED:  if (j_q == LAST) state_d = S_FIN;
      S_FIN:  state_d = (i_q == LAST) ? S_SUB : S_MUL;
      S_SUB:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    bus.done      = (state_q == S_DONE);
    bus.r         = r_q;
    bus.dbg_state = state_q;
  end

  // Shared multiplier operands: a*b in MUL, t0*m_inv in MQ, q*m in RED.
  always_comb begin
    jt      = TW'(j_q);
    jt_prev = jt - TW'(1);
    j_next  = (j_q == LAST) ? '0 : j_q + CW'(1);
    mul_x   = a_q[j_q];
    mul_y   = b_q[i_q];
    if (state_q == S_RED) begin
      mul_x = q_q;
      mul_y = m_q[j_q];
    end else if (state_q == S_MQ) begin
      mul_x = t_q[0];
      mul_y = minv_q;
    end
    prod       = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
    sum        = {{W{1'b0}}, t_q[jt]} + prod + {{W{1'b0}}, c_q};
    top_sum    = {1'b0, t_q[N]} + {1'b0, c_q};
    t_low      = t_q[N:0];
    sub_borrow = t_low < {{W{1'b0}}, m_q};
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    m_d    = m_q;
    minv_d = minv_q;
    t_d    = t_q;
    c_d    = c_q;
    q_d    = q_q;
    i_d    = i_q;
    j_d    = j_q;
    r_d    = r_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        a_d    = bus.a;
        b_d    = bus.b;
        m_d    = bus.m;
        minv_d = bus.m_inv;
        t_d    = '0;
        c_d    = '0;
        i_d    = '0;
        j_d    = '0;
      end
      S_MUL: begin
        t_d[jt] = sum[W-1:0];
        c_d     = sum[2*W-1:W];
        j_d     = j_next;
      end
      S_ACC: begin
        t_d[N]   = top_sum[W-1:0];
        t_d[N+1] = W'(top_sum[W]);
      end
      S_MQ: begin
        q_d = prod[W-1:0];
        c_d = '0;
      end
      S_RED: begin
        // The j=0 sum is zero by choice of q; later words shift down by one.
        if (j_q != '0) t_d[jt_prev] = sum[W-1:0];
        c_d = sum[2*W-1:W];
        j_d = j_next;
      end
      S_FIN: begin
        t_d[N-1] = top_sum[W-1:0];
        t_d[N]   = t_q[N+1] + W'(top_sum[W]);
        t_d[N+1] = '0;
        c_d      = '0;
        if (i_q != LAST) i_d = i_q + CW'(1);
      end
      S_SUB: r_d = sub_borrow ? t_q[N-1:0] : (t_q[N-1:0] - m_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      minv_q <= '0;
      t_q    <= '0;
      c_q    <= '0;
      q_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      r_q    <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      m_q    <= m_d;
      minv_q <= minv_d;
      t_q    <= t_d;
      c_q    <= c_d;
      q_q    <= q_d;
      i_q    <= i_d;
      j_q    <= j_d;
      r_q    <= r_d;
    end
  end
endmodule

// File: tb/tb_mont_mul_cios.sv
// Bench for mont_mul_cios: a 16-bit (8x2) instance under directed and random traffic and a 128-bit (32x4) instance.
// Expected results come from a modular-halving reference; a negedge monitor pops and compares on every done.
module tb_mont_mul_cios;
  localparam int LS = 16;
  localparam int LL = 46;
  localparam logic [127:0] P127 = (128'd1 << 127) - 128'd1;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mont_mul_cios_if #(.WORD_W(8),  .NUM_WORDS(2)) ifs ();
  mont_mul_cios_if #(.WORD_W(32), .NUM_WORDS(4)) ifl ();

  mont_mul_cios #(.WORD_W(8),  .NUM_WORDS(2)) dut_s (.clk(clk), .reset(reset), .bus(ifs));
  mont_mul_cios #(.WORD_W(32), .NUM_WORDS(4)) dut_l (.clk(clk), .reset(reset), .bus(ifl));

  int checks = 0;
  int errors = 0;
  int done_cnt_s = 0;

  logic [15:0]  exp_q[$];
  logic [15:0]  mod_q[$];
  int           acc_q[$];
  logic [127:0] exp_l_q[$];
  logic [127:0] mod_l_q[$];
  int           acc_l_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // a*b*2^-rbits mod m by repeated modular halving (m odd).
  function automatic logic [255:0] ref_mont(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] m, input int rbits);
    logic [255:0] x;
    x = (a * b) % m;
    for (int k = 0; k < rbits; k++) x = x[0] ? (x + m) >> 1 : x >> 1;
    return x;
  endfunction

  function automatic logic [7:0] calc_minv(input logic [7:0] m0);
    logic [7:0] xv;
    for (int x = 0; x < 256; x++) begin
      xv = 8'(x);
      if (8'(m0 * xv) == 8'd1) return 8'd0 - xv;
    end
    return 8'd0;
  endfunction

  always @(negedge clk) begin : mon_s
    logic [15:0] e, mm;
    int a0;
    if (ifs.done === 1'b1) begin
      done_cnt_s++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s_done: done pulse with no accepted start (cycle %0d)", cyc);
      end else begin
        e  = exp_q.pop_front();
        mm = mod_q.pop_front();
        a0 = acc_q.pop_front();
        check("s_r", ifs.r, e);
        check("s_r_lt_m", ifs.r < mm, 1);
        check("s_latency", cyc - a0 + 1, LS);
        check("s_busy_at_done", ifs.busy, 0);
      end
    end
  end

  always @(negedge clk) begin : mon_l
    logic [127:0] e, mm;
    int a0;
    if (ifl.done === 1'b1) begin
      if (exp_l_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL l_done: done pulse with no accepted start (cycle %0d)", cyc);
      end else begin
        e  = exp_l_q.pop_front();
        mm = mod_l_q.pop_front();
        a0 = acc_l_q.pop_front();
        check("l_r", ifl.r, e);
        check("l_r_lt_m", ifl.r < mm, 1);
        check("l_latency", cyc - a0 + 1, LL);
      end
    end
  end

  // Holds start until the engine accepts, then scrambles the inputs to prove they were latched.
  task automatic issue(input bit big, input logic [127:0] a, input logic [127:0] b,
                       input logic [127:0] m, input logic [31:0] mi, input logic [127:0] exp);
    bit acc;
    acc = 1'b0;
    if (big) begin
      ifl.a = a; ifl.b = b; ifl.m = m; ifl.m_inv = mi; ifl.start = 1'b1;
    end else begin
      ifs.a = a[15:0]; ifs.b = b[15:0]; ifs.m = m[15:0]; ifs.m_inv = mi[7:0]; ifs.start = 1'b1;
    end
    for (int k = 0; k < 8 && !acc; k++) begin
      @(posedge clk);
      #1;
      acc = big ? ifl.busy : ifs.busy;
    end
    check(big ? "l_accept" : "s_accept", acc, 1);
    if (acc) begin
      if (big) begin
        exp_l_q.push_back(exp); mod_l_q.push_back(m); acc_l_q.push_back(cyc);
      end else begin
        exp_q.push_back(exp[15:0]); mod_q.push_back(m[15:0]); acc_q.push_back(cyc);
      end
    end
    if (big) begin
      ifl.start = 1'b0; ifl.a = {4{$urandom}}; ifl.b = {4{$urandom}}; ifl.m = {4{$urandom}}; ifl.m_inv = $urandom;
    end else begin
      ifs.start = 1'b0; ifs.a = 16'($urandom); ifs.b = 16'($urandom); ifs.m = 16'($urandom); ifs.m_inv = 8'($urandom);
    end
  endtask

  task automatic wait_done(input bit big, output int at);
    at = -1;
    for (int k = 0; k < LL + 10 && at < 0; k++) begin
      @(negedge clk);
      if ((big ? ifl.done : ifs.done) === 1'b1) at = cyc;
    end
    check(big ? "l_done_timeout" : "s_done_timeout", at >= 0, 1);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int at, prev, nb, dc;
    logic [15:0]  ra, rb, rm;
    logic [7:0]   rmi;
    logic [127:0] la, lb;

    reset = 1'b1;
    ifs.start = 1'b0; ifs.a = '0; ifs.b = '0; ifs.m = '0; ifs.m_inv = '0;
    ifl.start = 1'b0; ifl.a = '0; ifl.b = '0; ifl.m = '0; ifl.m_inv = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_busy", ifs.busy, 0);
    check("rst_s_done", ifs.done, 0);
    check("rst_s_r", ifs.r, 0);
    check("rst_s_state", ifs.dbg_state, 0);
    check("rst_l_busy", ifl.busy, 0);
    check("rst_l_r", ifl.r, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // R mod m times b returns b; busy must cover exactly the 15 cycles before done.
    issue(0, 16'h000F, 16'h1234, 16'hFFF1, 8'hEF, 16'h1234);
    nb = 0;
    at = -1;
    for (int k = 0; k < 40 && at < 0; k++) begin
      @(negedge clk);
      if (ifs.done === 1'b1) at = cyc;
      else if (ifs.busy === 1'b1) nb++;
    end
    check("s_first_done", at >= 0, 1);
    check("s_busy_cycles", nb, LS - 1);

    issue(0, 16'hFFF0, 16'hFFF0, 16'hFFF1, 8'hEF, 16'hEEE1);
    wait_done(0, at);
    issue(0, 16'h0000, 16'hABCD, 16'hFFF1, 8'hEF, 16'h0000);
    wait_done(0, at);
    issue(0, 16'h000F, 16'h000F, 16'hFFF1, 8'hEF, 16'h000F);
    wait_done(0, at);

    // Back-to-back with start raised in each DONE cycle, alternating moduli.
    prev = at;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) issue(0, 16'h000F, 16'h0101, 16'hFFF1, 8'hEF, 16'h0101);
      else            issue(0, 16'h0005, 16'h0101, 16'hFFFB, 8'hCD, 16'h0101);
      wait_done(0, at);
      check("s_b2b_period", at - prev, LS + 1);
      prev = at;
    end

    // A start pulse while busy must be ignored.
    issue(0, 16'h000F, 16'h5678, 16'hFFF1, 8'hEF, 16'h5678);
    repeat (4) @(negedge clk);
    ifs.a = 16'h0123;
    ifs.start = 1'b1;
    @(posedge clk);
    #1;
    check("s_busy_ignore", ifs.busy, 1);
    @(negedge clk);
    ifs.start = 1'b0;
    wait_done(0, at);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    issue(0, 16'h000F, 16'h4321, 16'hFFF1, 8'hEF, 16'h4321);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back()); void'(mod_q.pop_back()); void'(acc_q.pop_back());
    end
    @(posedge clk);
    #1;
    check("abort_busy", ifs.busy, 0);
    check("abort_done", ifs.done, 0);
    check("abort_r", ifs.r, 0);
    @(negedge clk);
    reset = 1'b0;
    dc = done_cnt_s;
    repeat (LS + 6) @(negedge clk);
    check("abort_no_done", done_cnt_s, dc);
    issue(0, 16'h0005, 16'h2468, 16'hFFFB, 8'hCD, 16'h2468);
    wait_done(0, at);

    // 128-bit instance: 1*1*R^-1 mod (2^127-1) = 2^126, then random operands.
    @(negedge clk);
    issue(1, 128'd1, 128'd1, P127, 32'h0000_0001, 128'd1 << 126);
    wait_done(1, at);
    for (int k = 0; k < 4; k++) begin
      la = {4{$urandom}} % P127;
      lb = (k == 0) ? P127 - 128'd1 : {4{$urandom}} % P127;
      if (k == 0) la = P127 - 128'd1;
      issue(1, la, lb, P127, 32'h0000_0001, ref_mont(la, lb, P127, 128)[127:0]);
      wait_done(1, at);
    end

    // Random traffic on the 16-bit instance with random moduli and gaps.
    for (int n = 0; n < 1000; n++) begin
      rm  = 16'(2 * $urandom_range(128, 32767) + 1);
      ra  = 16'($urandom_range(0, int'(rm) - 1));
      rb  = 16'($urandom_range(0, int'(rm) - 1));
      rmi = calc_minv(rm[7:0]);
      issue(0, ra, rb, rm, rmi, ref_mont(ra, rb, rm, 16)[15:0]);
      wait_done(0, at);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("s_queue_empty", exp_q.size(), 0);
    check("l_queue_empty", exp_l_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
